stride_counter: RTL and testbench

Parametrised index generator for the sparse-dense multiply datapath, generalising the fixed-step even counter. It produces a registered index sequence from a programmable start value, stride and inclusive limit, with a selectable end-of-range mode: wrap, saturate or stop. It supplies a one-cycle wrap pulse and a sticky done flag to the row/column sequencing logic.

---
 rtl/counter_pkg.sv | 20 ++
 rtl/stride_counter_if.sv | 28 ++
 rtl/stride_next.sv | 20 ++
 rtl/stride_counter.sv | 92 +++++++++
 tb/tb_stride_counter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode and state encodings for the stride counter family
package counter_pkg;

    // End-of-range behaviour selected at load time; encoding 3 behaves as wrap.
    localparam logic [1:0] MODE_WRAP = 2'd0;
    localparam logic [1:0] MODE_SAT  = 2'd1;
    localparam logic [1:0] MODE_STOP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Everything that is not an explicit SAT or STOP reloads the start value.
    function automatic logic is_wrap_mode(input logic [1:0] mode);
        return (mode != MODE_SAT) && (mode != MODE_STOP);
    endfunction

endpackage

// File: rtl/stride_counter_if.sv
// rtl/stride_counter_if.sv - control/status bundle between sequencer and stride counter
// master: drives load/enable/config, observes count/wrap_pulse/done/busy.
// slave : the counter itself.
interface stride_counter_if #(
    parameter int COUNT_LEN = 10,
    parameter int STRIDE_W  = 4
);
    logic                 load;
    logic                 enable;
    logic [COUNT_LEN:0]   start_val;
    logic [STRIDE_W-1:0]  stride;
    logic [COUNT_LEN:0]   limit;
    logic [1:0]           mode;
    logic [COUNT_LEN:0]   count;
    logic                 wrap_pulse;
    logic                 done;
    logic                 busy;

    modport master (
        output load, enable, start_val, stride, limit, mode,
        input  count, wrap_pulse, done, busy
    );

    modport slave (
        input  load, enable, start_val, stride, limit, mode,
        output count, wrap_pulse, done, busy
    );
endinterface

// File: rtl/stride_next.sv
// rtl/stride_next.sv - combinational next-index and over-limit calculation
// Ports: count, stride, limit in; next (in-range candidate) and over flag out.
module stride_next #(
    parameter int COUNT_LEN = 10,
    parameter int STRIDE_W  = 4
) (
    input  logic [COUNT_LEN:0]  count,
    input  logic [STRIDE_W-1:0] stride,
    input  logic [COUNT_LEN:0]  limit,
    output logic [COUNT_LEN:0]  next,
    output logic                over
);
    // One extra bit so a sum past the top of the count range is seen as
    // over-limit instead of aliasing to a small value.
    logic [COUNT_LEN+1:0] sum;

    assign sum  = {1'b0, count} + {{(COUNT_LEN+2-STRIDE_W){1'b0}}, stride};
    assign over = sum > {1'b0, limit};
    assign next = sum[COUNT_LEN:0];
endmodule

// File: rtl/stride_counter.sv
// rtl/stride_counter.sv - programmable start/stride/limit index generator with wrap/sat/stop
// Ports: clk, reset (async active-low), bus (stride_counter_if.slave).
module stride_counter
    import counter_pkg::*;
#(
    parameter int COUNT_LEN = 10,
    parameter int STRIDE_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    stride_counter_if.slave  bus
);
    state_t               state_q, state_d;
    logic [COUNT_LEN:0]   count_q, count_d;
    logic                 wrap_q, wrap_d;
    logic [COUNT_LEN:0]   start_q;
    logic [STRIDE_W-1:0]  stride_q;
    logic [COUNT_LEN:0]   limit_q;
    logic [1:0]           mode_q;

    logic [COUNT_LEN:0]   next_val;
    logic                 over;
    logic                 step;

    stride_next #(
        .COUNT_LEN (COUNT_LEN),
        .STRIDE_W  (STRIDE_W)
    ) u_next (
        .count  (count_q),
        .stride (stride_q),
        .limit  (limit_q),
        .next   (next_val),
        .over   (over)
    );

    // A zero stride never moves, so it must never trip the terminal action,
    // even when the start value already sits above the limit.
    assign step = (state_q == ST_RUN) && bus.enable && !bus.load && (stride_q != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            wrap_q   <= 1'b0;
            start_q  <= '0;
            stride_q <= '0;
            limit_q  <= '0;
            mode_q   <= MODE_WRAP;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            if (bus.load) begin
                start_q  <= bus.start_val;
                stride_q <= bus.stride;
                limit_q  <= bus.limit;
                mode_q   <= bus.mode;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            state_d = ST_RUN;
        end else if (step && over && !is_wrap_mode(mode_q)) begin
            state_d = ST_DONE;
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.load) begin
            count_d = bus.start_val;
        end else if (step) begin
            if (!over) begin
                count_d = next_val;
            end else if (is_wrap_mode(mode_q)) begin
                count_d = start_q;
                wrap_d  = 1'b1;
            end else if (mode_q == MODE_SAT) begin
                count_d = limit_q;
            end
        end
    end

    assign bus.count      = count_q;
    assign bus.wrap_pulse = wrap_q;
    assign bus.done       = (state_q == ST_DONE);
    assign bus.busy       = (state_q == ST_RUN);
endmodule

// File: tb/tb_stride_counter.sv
// tb/tb_stride_counter.sv - directed scoreboard bench for stride_counter
module tb_stride_counter;
    logic clk;
    logic reset;

    int n_cmp;
    int n_fail;

    typedef struct packed {
        logic [10:0] count;
        logic        wrap;
        logic        done;
        logic        busy;
    } exp_t;

    exp_t  sb[$];
    string tq[$];

    stride_counter_if #(.COUNT_LEN(10), .STRIDE_W(4)) bus ();

    stride_counter #(.COUNT_LEN(10), .STRIDE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int c, input logic w, input logic d, input logic b);
        exp_t e;
        e.count = 11'(c);
        e.wrap  = w;
        e.done  = d;
        e.busy  = b;
        sb.push_back(e);
        tq.push_back(tag);
    endtask

    task automatic compare_out();
        exp_t  e;
        string t;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL scoreboard: observed empty required entry");
        end else begin
            e = sb.pop_front();
            t = tq.pop_front();
            chk({t, ".count"}, bus.count, e.count);
            chk({t, ".wrap"}, {10'd0, bus.wrap_pulse}, {10'd0, e.wrap});
            chk({t, ".done"}, {10'd0, bus.done}, {10'd0, e.done});
            chk({t, ".busy"}, {10'd0, bus.busy}, {10'd0, e.busy});
        end
    endtask

    task automatic cfg(input int sv, input int st, input int lim, input int md);
        bus.start_val = 11'(sv);
        bus.stride    = 4'(st);
        bus.limit     = 11'(lim);
        bus.mode      = 2'(md);
    endtask

    task automatic cyc(input logic ld, input logic en, input string tag,
                       input int c, input logic w, input logic d, input logic b);
        bus.load   = ld;
        bus.enable = en;
        push(tag, c, w, d, b);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bus.load   = 1'b0;
        bus.enable = 1'b0;
        cfg(0, 0, 0, 0);

        // Reset state.
        #1 reset = 1'b0;
        #1;
        push("reset", 0, 0, 0, 0);
        compare_out();
        #6 reset = 1'b1;

        // IDLE ignores enable.
        for (int i = 0; i < 10; i++) cyc(0, 1, "idle_en", 0, 0, 0, 0);

        // WRAP: 0,2,4,6,8,10,0.
        cfg(0, 2, 10, 0);
        cyc(1, 0, "wrap_ld", 0, 0, 0, 1);
        cyc(0, 1, "wrap_s1", 2, 0, 0, 1);
        cyc(0, 1, "wrap_s2", 4, 0, 0, 1);
        cyc(0, 1, "wrap_s3", 6, 0, 0, 1);
        cyc(0, 1, "wrap_s4", 8, 0, 0, 1);
        cyc(0, 1, "wrap_s5", 10, 0, 0, 1);
        cyc(0, 1, "wrap_s6", 0, 1, 0, 1);
        cyc(0, 1, "wrap_s7", 2, 0, 0, 1);
        cyc(0, 0, "wrap_hold", 2, 0, 0, 1);

        // SAT: 1,5,9,10 then done and frozen.
        cfg(1, 4, 10, 1);
        cyc(1, 0, "sat_ld", 1, 0, 0, 1);
        cyc(0, 1, "sat_s1", 5, 0, 0, 1);
        cyc(0, 1, "sat_s2", 9, 0, 0, 1);
        cyc(0, 1, "sat_s3", 10, 0, 1, 0);
        cyc(0, 1, "sat_frz", 10, 0, 1, 0);

        // Exact hit on the limit stays in RUN; terminal action on next step.
        cfg(0, 5, 10, 1);
        cyc(1, 0, "eq_ld", 0, 0, 0, 1);
        cyc(0, 1, "eq_s1", 5, 0, 0, 1);
        cyc(0, 1, "eq_s2", 10, 0, 0, 1);
        cyc(0, 1, "eq_s3", 10, 0, 1, 0);

        // STOP: 1,5,9,9 then reload to 3.
        cfg(1, 4, 10, 2);
        cyc(1, 0, "stop_ld", 1, 0, 0, 1);
        cyc(0, 1, "stop_s1", 5, 0, 0, 1);
        cyc(0, 1, "stop_s2", 9, 0, 0, 1);
        cyc(0, 1, "stop_s3", 9, 0, 1, 0);
        cyc(0, 1, "stop_frz", 9, 0, 1, 0);
        cfg(3, 4, 10, 2);
        cyc(1, 0, "stop_rld", 3, 0, 0, 1);

        // Mode 3 behaves as WRAP.
        cfg(0, 3, 5, 3);
        cyc(1, 0, "m3_ld", 0, 0, 0, 1);
        cyc(0, 1, "m3_s1", 3, 0, 0, 1);
        cyc(0, 1, "m3_s2", 0, 1, 0, 1);

        // Start above limit under WRAP: back-to-back reloads and pulses.
        cfg(12, 1, 10, 0);
        cyc(1, 0, "hi_ld", 12, 0, 0, 1);
        cyc(0, 1, "hi_s1", 12, 1, 0, 1);
        cyc(0, 1, "hi_s2", 12, 1, 0, 1);
        cyc(0, 0, "hi_idle", 12, 0, 0, 1);

        // Width boundary: 2040+15 must not alias.
        cfg(2040, 15, 2047, 0);
        cyc(1, 0, "wid_ld", 2040, 0, 0, 1);
        cyc(0, 1, "wid_s1", 2040, 1, 0, 1);

        // Zero stride holds with no wrap and no done, even above the limit.
        cfg(5, 0, 10, 0);
        cyc(1, 0, "z_ld", 5, 0, 0, 1);
        cyc(0, 1, "z_s1", 5, 0, 0, 1);
        cfg(12, 0, 10, 1);
        cyc(1, 0, "z2_ld", 12, 0, 0, 1);
        cyc(0, 1, "z2_s1", 12, 0, 0, 1);

        // Load and enable together: load wins, no step.
        cfg(7, 2, 20, 0);
        cyc(1, 1, "le_ld", 7, 0, 0, 1);
        cyc(0, 1, "le_s1", 9, 0, 0, 1);

        // Load out of DONE.
        cfg(0, 8, 4, 2);
        cyc(1, 0, "dn_ld", 0, 0, 0, 1);
        cyc(0, 1, "dn_s1", 0, 0, 1, 0);
        cfg(6, 1, 9, 0);
        cyc(1, 1, "dn_rld", 6, 0, 0, 1);

        // Asynchronous reset mid-RUN at count=6.
        cfg(0, 2, 10, 0);
        cyc(1, 0, "ar_ld", 0, 0, 0, 1);
        cyc(0, 1, "ar_s1", 2, 0, 0, 1);
        cyc(0, 1, "ar_s2", 4, 0, 0, 1);
        cyc(0, 1, "ar_s3", 6, 0, 0, 1);
        #3 reset = 1'b0;
        #1;
        push("ar_async", 0, 0, 0, 0);
        compare_out();
        #1 reset = 1'b1;
        cyc(0, 1, "ar_idle", 0, 0, 0, 0);

        bus.load   = 1'b0;
        bus.enable = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
